mem_stage: RTL

- Pipeline MEM stage, directly downstream of the EX stage; consumes its registered outputs (ALU result, load/store op, mul/div flags, dest, store data).
- Issues data-memory requests on a req/addr_ok/data_ok SRAM-like bus.
- Collects multiplier and divider responses and selects/extracts the final writeback value.
- Registers the result toward WB using the same valid/ready handshake as the rest of the pipeline.

---
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - SRAM-like data-memory bus between the MEM stage and data memory
// The stage is the master: it raises req, memory answers with addr_ok then data_ok.
interface mem_stage_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: data-memory access, mul/div collection, WB register
// A three-state FSM tracks the one outstanding memory transaction of the current instruction.
module mem_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  input  logic [31:0] pc_i,
  input  logic [7:0]  load_op_i,
  input  logic [2:0]  mul_op_i,
  input  logic [3:0]  div_op_i,
  input  logic        res_from_mul_i,
  input  logic        res_from_div_i,
  input  logic        res_from_mem_i,
  input  logic        gr_we_i,
  input  logic        mem_we_i,
  input  logic [4:0]  dest_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rkd_value_i,
  input  logic        mul_resp_valid_i,
  output logic        mul_resp_ready_o,
  input  logic [63:0] mul_result_i,
  input  logic        div_resp_valid_i,
  output logic        div_resp_ready_o,
  input  logic [31:0] div_quotient_i,
  input  logic [31:0] div_remainder_i,
  mem_stage_if.master dsram,
  output logic [31:0] pc_out_o,
  output logic        gr_we_out_o,
  output logic [4:0]  dest_out_o,
  output logic [31:0] final_result_out_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, HOLD = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_buf_q;
  logic        out_valid_q;
  logic [31:0] pc_out_q;
  logic        gr_we_out_q;
  logic [4:0]  dest_out_q;
  logic [31:0] final_result_q;

  logic        mem_op, ready_go, handoff, sram_req, buf_we;
  logic        is_byte, is_half;
  logic [31:0] load_src, load_shifted, mem_result, final_result_d;

  assign mem_op   = in_valid_i & (res_from_mem_i | mem_we_i);
  assign ready_go = ~in_valid_i |
                    ((~mem_op | ((state_q == DATA) & dsram.data_sram_data_ok) | (state_q == HOLD)) &
                     (~res_from_mul_i | mul_resp_valid_i) &
                     (~res_from_div_i | div_resp_valid_i));
  assign handoff  = in_valid_i & ready_go & out_ready_i;

  assign in_ready_o       = ~rst & (~in_valid_i | (ready_go & out_ready_i));
  assign mul_resp_ready_o = in_valid_i & res_from_mul_i & out_ready_i & ready_go;
  assign div_resp_ready_o = in_valid_i & res_from_div_i & out_ready_i & ready_go;

  always_comb begin
    state_d  = state_q;
    sram_req = 1'b0;
    buf_we   = 1'b0;
    case (state_q)
      IDLE: begin
        sram_req = mem_op;
        if (mem_op & dsram.data_sram_addr_ok) state_d = DATA;
      end
      DATA: begin
        // Without a same-cycle handoff the response would be lost, so park it.
        if (dsram.data_sram_data_ok) begin
          if (handoff) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            buf_we  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (handoff) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rdata_buf_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (buf_we) rdata_buf_q <= dsram.data_sram_rdata;
    end
  end

  assign is_byte = load_op_i[0] | load_op_i[3] | load_op_i[5];
  assign is_half = load_op_i[1] | load_op_i[4] | load_op_i[6];

  always_comb begin
    dsram.data_sram_req   = sram_req;
    dsram.data_sram_wr    = mem_we_i;
    dsram.data_sram_addr  = alu_result_i;
    dsram.data_sram_size  = is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd2);
    dsram.data_sram_wstrb = 4'b0000;
    dsram.data_sram_wdata = rkd_value_i;
    if (load_op_i[5]) begin
      dsram.data_sram_wstrb = 4'b0001 << alu_result_i[1:0];
      dsram.data_sram_wdata = {4{rkd_value_i[7:0]}};
    end else if (load_op_i[6]) begin
      dsram.data_sram_wstrb = alu_result_i[1] ? 4'b1100 : 4'b0011;
      dsram.data_sram_wdata = {2{rkd_value_i[15:0]}};
    end else if (load_op_i[7]) begin
      dsram.data_sram_wstrb = 4'b1111;
    end
  end

  assign load_src     = (state_q == HOLD) ? rdata_buf_q : dsram.data_sram_rdata;
  assign load_shifted = load_src >> {alu_result_i[1:0], 3'b000};

  always_comb begin
    mem_result = load_shifted;
    if (load_op_i[0])      mem_result = {{24{load_shifted[7]}}, load_shifted[7:0]};
    else if (load_op_i[1]) mem_result = {{16{load_shifted[15]}}, load_shifted[15:0]};
    else if (load_op_i[3]) mem_result = {24'h0, load_shifted[7:0]};
    else if (load_op_i[4]) mem_result = {16'h0, load_shifted[15:0]};
  end

  always_comb begin
    final_result_d = alu_result_i;
    if (res_from_mem_i)
      final_result_d = mem_result;
    else if (res_from_mul_i)
      final_result_d = (mul_op_i[2] | mul_op_i[1]) ? mul_result_i[63:32] : mul_result_i[31:0];
    else if (res_from_div_i)
      final_result_d = (div_op_i[0] | div_op_i[2]) ? div_quotient_i : div_remainder_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      pc_out_q       <= RESET_PC;
      gr_we_out_q    <= 1'b0;
      dest_out_q     <= 5'd0;
      final_result_q <= 32'h0;
    end else begin
      if (out_ready_i) out_valid_q <= in_valid_i & ready_go;
      if (handoff) begin
        pc_out_q       <= pc_i;
        gr_we_out_q    <= gr_we_i;
        dest_out_q     <= dest_i;
        final_result_q <= final_result_d;
      end
    end
  end

  assign out_valid_o        = out_valid_q;
  assign pc_out_o           = pc_out_q;
  assign gr_we_out_o        = gr_we_out_q;
  assign dest_out_o         = dest_out_q;
  assign final_result_out_o = final_result_q;

endmodule
